// File: rtl/router_pkg.sv
// Shared types and constants for the 1x3 packet router ingress path.
package router_pkg;

    localparam int WIDTH_DEFAULT   = 8;
    localparam int NUM_PORTS       = 3;
    localparam int TIMEOUT_DEFAULT = 30;

    localparam logic [1:0] ADDR_INVALID = 2'b11;

    // Header byte layout: payload length in the upper six bits, destination below.
    localparam int HDR_LEN_MSB  = 7;
    localparam int HDR_LEN_LSB  = 2;
    localparam int HDR_ADDR_MSB = 1;
    localparam int HDR_ADDR_LSB = 0;

    typedef logic [5:0] len_t;
    localparam len_t LEN_MAX = 6'h3F;

    typedef enum logic [2:0] {
        DECODE_ADDRESS,
        WAIT_TILL_EMPTY,
        LOAD_FIRST_DATA,
        WRITE_HEADER,
        LOAD_DATA,
        LOAD_PARITY,
        CHECK_PARITY_ERROR,
        DROP_PACKET
    } state_t;

endpackage

// File: rtl/router_ingress_ctrl_if.sv
// Source-side byte stream plus the FIFO-side control/status bundle of the ingress controller.
interface router_ingress_ctrl_if #(
    parameter int WIDTH     = router_pkg::WIDTH_DEFAULT,
    parameter int NUM_PORTS = router_pkg::NUM_PORTS
);
    logic                 pkt_valid;
    logic [WIDTH-1:0]     data_in;
    logic [NUM_PORTS-1:0] fifo_full;
    logic [NUM_PORTS-1:0] fifo_empty;
    logic [NUM_PORTS-1:0] read_enb;
    logic                 busy;
    logic [WIDTH-1:0]     dout;
    logic [NUM_PORTS-1:0] write_enb;
    logic                 lfd_state;
    logic [NUM_PORTS-1:0] soft_reset;
    logic [NUM_PORTS-1:0] vld_out;
    logic                 err;

    modport master (
        output pkt_valid, data_in, fifo_full, fifo_empty, read_enb,
        input  busy, dout, write_enb, lfd_state, soft_reset, vld_out, err
    );

    modport slave (
        input  pkt_valid, data_in, fifo_full, fifo_empty, read_enb,
        output busy, dout, write_enb, lfd_state, soft_reset, vld_out, err
    );

endinterface

// File: rtl/router_timeout.sv
// Per-FIFO stall watchdog: pulses soft_reset once the reader has ignored valid data for TIMEOUT cycles.
module router_timeout #(
    parameter int TIMEOUT = router_pkg::TIMEOUT_DEFAULT
) (
    input  logic clock,
    input  logic resetn,
    input  logic vld_out,
    input  logic read_enb,
    input  logic fifo_empty,
    output logic soft_reset
);
    import router_pkg::*;

    localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(TIMEOUT - 1);

    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            cnt        <= '0;
            soft_reset <= 1'b0;
        end else begin
            soft_reset <= 1'b0;
            if (read_enb || fifo_empty) begin
                cnt <= '0;
            end else if (vld_out) begin
                if (cnt == LAST) begin
                    cnt        <= '0;
                    soft_reset <= 1'b1;
                end else begin
                    cnt <= cnt + 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/router_ingress_ctrl.sv
// Router ingress: decodes headers, steers bytes into the destination FIFO,
// checks parity/length and flushes FIFOs whose reader has stalled.
module router_ingress_ctrl #(
    parameter int WIDTH     = router_pkg::WIDTH_DEFAULT,
    parameter int NUM_PORTS = router_pkg::NUM_PORTS,
    parameter int TIMEOUT   = router_pkg::TIMEOUT_DEFAULT
) (
    input logic                  clock,
    input logic                  resetn,
    router_ingress_ctrl_if.slave bus
);
    import router_pkg::*;

    state_t               state;
    logic [WIDTH-1:0]     hdr_reg;
    logic [WIDTH-1:0]     parity_acc;
    logic [1:0]           addr;
    len_t                 len_cnt;
    logic                 err_q;
    logic                 lfd_q;
    logic [NUM_PORTS-1:0] soft_reset;
    logic [NUM_PORTS-1:0] vld_out;
    logic [NUM_PORTS-1:0] write_enb;
    logic [WIDTH-1:0]     dout;
    logic [1:0]           hdr_addr;
    logic                 full_sel;
    logic                 soft_sel;
    logic                 in_packet;
    logic                 busy;
    logic                 wr;

    assign hdr_addr  = bus.data_in[HDR_ADDR_MSB:HDR_ADDR_LSB];
    assign full_sel  = bus.fifo_full[addr];
    assign soft_sel  = soft_reset[addr];
    assign in_packet = state inside {WAIT_TILL_EMPTY, LOAD_FIRST_DATA, WRITE_HEADER,
                                     LOAD_DATA, LOAD_PARITY};
    assign vld_out   = ~bus.fifo_empty;

    for (genvar i = 0; i < NUM_PORTS; i++) begin : g_timeout
        router_timeout #(.TIMEOUT(TIMEOUT)) u_timeout (
            .clock      (clock),
            .resetn     (resetn),
            .vld_out    (vld_out[i]),
            .read_enb   (bus.read_enb[i]),
            .fifo_empty (bus.fifo_empty[i]),
            .soft_reset (soft_reset[i])
        );
    end

    // A flush of the active FIFO suppresses every write, including the parity byte.
    always_comb begin
        busy = 1'b0;
        wr   = 1'b0;
        dout = '0;
        case (state)
            WAIT_TILL_EMPTY, LOAD_FIRST_DATA, CHECK_PARITY_ERROR: busy = 1'b1;
            WRITE_HEADER: begin
                busy = 1'b1;
                wr   = ~soft_sel;
                dout = hdr_reg;
            end
            LOAD_DATA: begin
                busy = full_sel;
                wr   = bus.pkt_valid & ~full_sel & ~soft_sel;
                dout = bus.data_in;
            end
            LOAD_PARITY: begin
                busy = full_sel;
                wr   = ~full_sel & ~soft_sel;
                dout = bus.data_in;
            end
            default: ;
        endcase
        write_enb = '0;
        if (wr) write_enb[addr] = 1'b1;
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state      <= DECODE_ADDRESS;
            hdr_reg    <= '0;
            addr       <= '0;
            parity_acc <= '0;
            len_cnt    <= '0;
            err_q      <= 1'b0;
            lfd_q      <= 1'b0;
        end else begin
            lfd_q <= 1'b0;
            if (in_packet && soft_sel) begin
                state <= DROP_PACKET;
            end else begin
                case (state)
                    DECODE_ADDRESS: begin
                        if (bus.pkt_valid) begin
                            if (hdr_addr == ADDR_INVALID) begin
                                state <= DROP_PACKET;
                            end else begin
                                hdr_reg    <= bus.data_in;
                                addr       <= hdr_addr;
                                parity_acc <= bus.data_in;
                                len_cnt    <= '0;
                                err_q      <= 1'b0;
                                if (bus.fifo_empty[hdr_addr]) begin
                                    state <= LOAD_FIRST_DATA;
                                    lfd_q <= 1'b1;
                                end else begin
                                    state <= WAIT_TILL_EMPTY;
                                end
                            end
                        end
                    end
                    WAIT_TILL_EMPTY: begin
                        if (bus.fifo_empty[addr]) begin
                            state <= LOAD_FIRST_DATA;
                            lfd_q <= 1'b1;
                        end
                    end
                    LOAD_FIRST_DATA: state <= WRITE_HEADER;
                    WRITE_HEADER:    state <= LOAD_DATA;
                    LOAD_DATA: begin
                        if (!bus.pkt_valid) begin
                            state <= LOAD_PARITY;
                        end else if (!full_sel) begin
                            parity_acc <= parity_acc ^ bus.data_in;
                            if (len_cnt != LEN_MAX) len_cnt <= len_cnt + 1'b1;
                        end
                    end
                    LOAD_PARITY: begin
                        if (!full_sel) begin
                            err_q <= (bus.data_in != parity_acc) ||
                                     (len_cnt != hdr_reg[HDR_LEN_MSB:HDR_LEN_LSB]);
                            state <= CHECK_PARITY_ERROR;
                        end
                    end
                    CHECK_PARITY_ERROR: state <= DECODE_ADDRESS;
                    DROP_PACKET: begin
                        if (!bus.pkt_valid) state <= DECODE_ADDRESS;
                    end
                    default: state <= DECODE_ADDRESS;
                endcase
            end
        end
    end

    assign bus.busy       = busy;
    assign bus.dout       = dout;
    assign bus.write_enb  = write_enb;
    assign bus.lfd_state  = lfd_q;
    assign bus.soft_reset = soft_reset;
    assign bus.vld_out    = vld_out;
    assign bus.err        = err_q;

endmodule
